// File: rtl/fp_mult_exp_pipe.sv
// ---------------------------------------------------------------------------
// fp_mult_exp_pipe
//
// Two-stage pipelined exponent datapath for the floating-point multiplier.
// Stage 1 adds the two biased operand exponents and the mantissa
// normalisation carry. It also records which operands are zero/denormal
// (exponent 0) or special (exponent all-ones).
// Stage 2 removes the bias and classifies the result as NaN, infinity,
// zero, overflow, underflow or normal. It presents a registered exponent
// plus at most one class flag.
//
// Flow control is valid/ready with full backpressure. A result held in
// stage 2 stays stable until the consumer takes it.
//
// Parameters
//   EXP_W     exponent width (8 single, 11 double, 5 half)
//   BIAS      exponent bias, (1<<(EXP_W-1))-1 by default
//
// Ports
//   clk_50    system clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  operand exponents valid
//   in_ready  pipeline can accept operands this cycle
//   a_exp     biased exponent of operand A
//   b_exp     biased exponent of operand B
//   norm_inc  mantissa product carry, adds one to the exponent
//   out_valid result valid
//   out_ready consumer accepts the result
//   exp_res   result biased exponent
//   flag_ovf  overflow, exp_res all-ones
//   flag_unf  underflow, exp_res zero
//   flag_zero an operand is zero/denormal (flushed), exp_res zero
//   flag_inf  an operand is all-ones and the other nonzero, exp_res all-ones
//   flag_nan  one operand all-ones and the other zero, exp_res all-ones
// ---------------------------------------------------------------------------
module fp_mult_exp_pipe #(
  parameter int EXP_W = 8,
  parameter int BIAS  = (1 << (EXP_W - 1)) - 1
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [EXP_W-1:0] b_exp,
  input  logic             norm_inc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_res,
  output logic             flag_ovf,
  output logic             flag_unf,
  output logic             flag_zero,
  output logic             flag_inf,
  output logic             flag_nan
);

  // Two guard bits: one holds the carry of the add, the other acts as a
  // sign bit once the bias has been removed.
  localparam int SUM_W = EXP_W + 2;
  localparam logic [SUM_W-1:0] BIAS_EXT = SUM_W'(BIAS);
  // Smallest unbiased value that no longer fits as a finite exponent.
  localparam logic [EXP_W:0] OVF_LIM = (EXP_W + 1)'((1 << EXP_W) - 1);

  logic             s1_valid;
  logic [SUM_W-1:0] s1_sum;
  logic             s1_a_zero;
  logic             s1_b_zero;
  logic             s1_a_max;
  logic             s1_b_max;

  logic             in_fire;
  logic             s2_load;
  logic [SUM_W-1:0] sum_next;
  logic [SUM_W-1:0] unbiased;
  logic             unb_neg;
  logic             unb_zero;
  logic             unb_ovf;

  logic [EXP_W-1:0] next_exp;
  logic             next_ovf;
  logic             next_unf;
  logic             next_zero;
  logic             next_inf;
  logic             next_nan;

  // Stage 2 frees up whenever it is empty or its result leaves this cycle.
  // Stage 1 can then accept new operands if it is empty or moves forward.
  // in_ready therefore depends on pipeline state and out_ready only.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;

  // Zero-extended add of both exponents and the normalisation carry.
  assign sum_next = {2'b00, a_exp} + {2'b00, b_exp} + {{(SUM_W - 1){1'b0}}, norm_inc};

  // Remove the bias. The top bit of the result is its sign.
  assign unbiased = s1_sum - BIAS_EXT;
  assign unb_neg  = unbiased[SUM_W-1];
  assign unb_zero = (unbiased == '0);
  assign unb_ovf  = !unb_neg && (unbiased[EXP_W:0] >= OVF_LIM);

  // Result classification. Special operands take priority over range
  // checks on the computed exponent. Earlier tests win.
  always_comb begin
    next_exp  = unbiased[EXP_W-1:0];
    next_ovf  = 1'b0;
    next_unf  = 1'b0;
    next_zero = 1'b0;
    next_inf  = 1'b0;
    next_nan  = 1'b0;
    if ((s1_a_max && s1_b_zero) || (s1_b_max && s1_a_zero)) begin
      next_nan = 1'b1;
      next_exp = '1;
    end else if (s1_a_max || s1_b_max) begin
      next_inf = 1'b1;
      next_exp = '1;
    end else if (s1_a_zero || s1_b_zero) begin
      next_zero = 1'b1;
      next_exp  = '0;
    end else if (unb_ovf) begin
      next_ovf = 1'b1;
      next_exp = '1;
    end else if (unb_neg || unb_zero) begin
      next_unf = 1'b1;
      next_exp = '0;
    end
  end

  // Stage 1: capture the raw sum and the operand class bits when operands
  // are accepted. Mark the stage empty once its contents move on without
  // a replacement.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_a_zero <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_a_max  <= 1'b0;
      s1_b_max  <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid  <= 1'b1;
        s1_sum    <= sum_next;
        s1_a_zero <= (a_exp == '0);
        s1_b_zero <= (b_exp == '0);
        s1_a_max  <= (a_exp == '1);
        s1_b_max  <= (b_exp == '1);
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: registered result and flags. The result holds while the
  // consumer stalls. out_valid drops once the result is taken and
  // nothing follows it.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      exp_res   <= '0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_zero <= 1'b0;
      flag_inf  <= 1'b0;
      flag_nan  <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        exp_res   <= next_exp;
        flag_ovf  <= next_ovf;
        flag_unf  <= next_unf;
        flag_zero <= next_zero;
        flag_inf  <= next_inf;
        flag_nan  <= next_nan;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
